wb_fabric_nxm: RTL and testbench

Parametrised Wishbone B4 classic shared-bus fabric: it connects NUM_MASTERS masters to NUM_SLAVES slaves through one shared channel. It is the successor to the fixed one-master/five-slave interconnect in the SoC top. Relative to that interconnect it adds:
- round-robin arbitration between masters;
- a programmable base/mask address map;
- an error response for unmapped addresses;
- a bus-timeout watchdog.

It sits between the core's Wishbone controller (plus a debug/boot-loader master) and the memories and peripherals.

---
 rtl/wb_fabric_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/wb_fabric_nxm.sv | 163 ++++++++++++++++
 tb/tb_wb_fabric_nxm.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_fabric_pkg.sv
// Shared types and default SoC address map for the N-master/M-slave Wishbone fabric.
package wb_fabric_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, RESP_ERR} state_e;

   localparam int SOC_NUM_SLAVES = 5;

   // Slave 0 sits in the least-significant 32 bits.
   localparam logic [SOC_NUM_SLAVES*32-1:0] SOC_SLAVE_BASE = {
      32'h2100_0000, 32'h2000_0100, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
   };
   localparam logic [SOC_NUM_SLAVES*32-1:0] SOC_SLAVE_MASK = {
      32'hFF00_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000
   };

   function automatic int max_masters();
      return 4;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the rotating pointer.
module rr_arbiter
   import wb_fabric_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = $clog2(max_masters());

   logic [PW-1:0] ptr;
   int            win;

   // Walk from the farthest to the nearest candidate so the nearest requester wins.
   always_comb begin
      // NOTE: defaults first so no path leaves grant/win unassigned (avoids inferred latches).
      grant = '0;
      win   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            grant                        = '0;
            grant[(int'(ptr) + k) % N]   = 1'b1;
            win                          = (int'(ptr) + k) % N;
         end
      end
   end

   // The pointer moves past a master as soon as its grant is taken; no other
   // arbitration happens while that transaction is outstanding.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance && |req) begin
         ptr <= PW'((win + 1) % N);
      end
   end

endmodule

// File: rtl/wb_fabric_nxm.sv
// Shared-bus Wishbone B4 classic fabric: round-robin masters, base/mask decode, error and watchdog.
module wb_fabric_nxm
   import wb_fabric_pkg::*;
#(
   parameter int                         NUM_MASTERS = 2,
   parameter int                         NUM_SLAVES  = 5,
   parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE  = SOC_SLAVE_BASE,
   parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK  = SOC_SLAVE_MASK,
   parameter int                         TIMEOUT     = 255
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   input  logic [NUM_MASTERS*32-1:0]   m_adr_i,
   input  logic [NUM_MASTERS*32-1:0]   m_dat_i,
   input  logic [NUM_MASTERS*4-1:0]    m_sel_i,
   input  logic [NUM_MASTERS-1:0]      m_we_i,
   input  logic [NUM_MASTERS-1:0]      m_cyc_i,
   input  logic [NUM_MASTERS-1:0]      m_stb_i,
   output logic [NUM_MASTERS*32-1:0]   m_dat_o,
   output logic [NUM_MASTERS-1:0]      m_ack_o,
   output logic [NUM_MASTERS-1:0]      m_err_o,
   output logic [NUM_MASTERS-1:0]      m_rty_o,
   output logic [31:0]                 s_adr_o,
   output logic [31:0]                 s_dat_o,
   output logic [3:0]                  s_sel_o,
   output logic                        s_we_o,
   output logic [NUM_SLAVES-1:0]       s_cyc_o,
   output logic [NUM_SLAVES-1:0]       s_stb_o,
   input  logic [NUM_SLAVES*32-1:0]    s_dat_i,
   input  logic [NUM_SLAVES-1:0]       s_ack_i,
   input  logic [NUM_SLAVES-1:0]       s_err_i,
   input  logic [NUM_SLAVES-1:0]       s_rty_i,
   output logic [NUM_MASTERS-1:0]      grant_o,
   output logic                        timeout_o
);

   localparam int CW = $clog2(TIMEOUT);

   state_e                  state;
   logic [NUM_MASTERS-1:0]  req, arb_grant, owner;
   logic [NUM_SLAVES-1:0]   hit, slave_sel;
   logic [CW-1:0]           wd_cnt;
   logic                    busy;
   logic [31:0]             arb_adr, own_adr, own_dat, sl_dat;
   logic [3:0]              own_sel;
   logic                    own_we, own_cyc, own_stb;
   logic                    sl_ack, sl_err, sl_rty, term;

   assign req  = m_cyc_i & m_stb_i;
   assign busy = (state == BUSY);

   rr_arbiter #(.N(NUM_MASTERS)) u_arb (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .req     (req),
      .advance (state == IDLE),
      .grant   (arb_grant)
   );

   // arb_adr feeds the decode of the master about to be granted; own_* is the registered owner.
   always_comb begin
      arb_adr = '0;
      own_adr = '0;
      own_dat = '0;
      own_sel = '0;
      own_we  = 1'b0;
      own_cyc = 1'b0;
      own_stb = 1'b0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
         if (arb_grant[m]) arb_adr = m_adr_i[m*32 +: 32];
         if (owner[m]) begin
            own_adr = m_adr_i[m*32 +: 32];
            own_dat = m_dat_i[m*32 +: 32];
            own_sel = m_sel_i[m*4 +: 4];
            own_we  = m_we_i[m];
            own_cyc = m_cyc_i[m];
            own_stb = m_stb_i[m];
         end
      end
   end

   // Descending scan so the lowest matching slave index overrides any higher match.
   always_comb begin
      hit    = '0;
      sl_dat = '0;
      sl_ack = 1'b0;
      sl_err = 1'b0;
      sl_rty = 1'b0;
      for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
         if ((arb_adr & SLAVE_MASK[s*32 +: 32]) == SLAVE_BASE[s*32 +: 32]) begin
            hit    = '0;
            hit[s] = 1'b1;
         end
      end
      for (int s = 0; s < NUM_SLAVES; s++) begin
         if (slave_sel[s]) begin
            sl_dat = s_dat_i[s*32 +: 32];
            sl_ack = s_ack_i[s];
            sl_err = s_err_i[s];
            sl_rty = s_rty_i[s];
         end
      end
   end

   assign term = sl_ack | sl_err | sl_rty;

   always_comb begin
      s_adr_o = busy ? own_adr : '0;
      s_dat_o = busy ? own_dat : '0;
      s_sel_o = busy ? own_sel : '0;
      s_we_o  = busy & own_we;
      s_cyc_o = (busy && own_cyc) ? slave_sel : '0;
      s_stb_o = (busy && own_cyc && own_stb) ? slave_sel : '0;
      grant_o = (state == IDLE) ? '0 : owner;
      m_dat_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      m_rty_o = '0;
      // Error beats ack, ack beats retry when a slave raises several at once.
      for (int m = 0; m < NUM_MASTERS; m++) begin
         if (owner[m]) begin
            m_dat_o[m*32 +: 32] = busy ? sl_dat : '0;
            m_err_o[m]          = (busy && sl_err) || (state == RESP_ERR);
            m_ack_o[m]          = busy && sl_ack && !sl_err;
            m_rty_o[m]          = busy && sl_rty && !sl_err && !sl_ack;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         owner     <= '0;
         slave_sel <= '0;
         wd_cnt    <= '0;
         timeout_o <= 1'b0;
      end else begin
         timeout_o <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  owner     <= arb_grant;
                  slave_sel <= hit;
                  wd_cnt    <= '0;
                  state     <= (|hit) ? BUSY : RESP_ERR;
               end
            end
            BUSY: begin
               if (term || !own_cyc) begin
                  state <= IDLE;
               end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                  state     <= RESP_ERR;
                  timeout_o <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_fabric_nxm.sv
// Self-checking bench for wb_fabric_nxm: directed scenarios plus randomized single-master traffic.
module tb_wb_fabric_nxm;

   localparam int NM  = 2;
   localparam int NS  = 5;
   localparam int TMO = 4;
   localparam int AW  = NM*36 + 69 + 2*NS + 1;

   // Slave 3 is moved onto slave 1's base to exercise overlapping map entries.
   localparam logic [NS*32-1:0] TB_BASE = {
      32'h2100_0000, 32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
   };
   localparam logic [NS*32-1:0] TB_MASK = {
      32'hFF00_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000
   };

   typedef enum int {R_ACK, R_ERR, R_RTY, R_BOTH} resp_e;

   logic              clk = 1'b0;
   logic              wb_rst_i;
   logic [NM*32-1:0]  m_adr_i, m_dat_i, m_dat_o;
   logic [NM*4-1:0]   m_sel_i;
   logic [NM-1:0]     m_we_i, m_cyc_i, m_stb_i, m_ack_o, m_err_o, m_rty_o, grant_o;
   logic [31:0]       s_adr_o, s_dat_o;
   logic [3:0]        s_sel_o;
   logic              s_we_o, timeout_o;
   logic [NS-1:0]     s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;
   logic [NS*32-1:0]  s_dat_i;
   logic [31:0]       rdat [NS];
   logic [AW-1:0]     all_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_fabric_nxm #(
      .NUM_MASTERS (NM),
      .NUM_SLAVES  (NS),
      .SLAVE_BASE  (TB_BASE),
      .SLAVE_MASK  (TB_MASK),
      .TIMEOUT     (TMO)
   ) dut (
      .wb_clk_i (clk),     .wb_rst_i (wb_rst_i),
      .m_adr_i  (m_adr_i), .m_dat_i  (m_dat_i),  .m_sel_i (m_sel_i),
      .m_we_i   (m_we_i),  .m_cyc_i  (m_cyc_i),  .m_stb_i (m_stb_i),
      .m_dat_o  (m_dat_o), .m_ack_o  (m_ack_o),  .m_err_o (m_err_o), .m_rty_o (m_rty_o),
      .s_adr_o  (s_adr_o), .s_dat_o  (s_dat_o),  .s_sel_o (s_sel_o), .s_we_o  (s_we_o),
      .s_cyc_o  (s_cyc_o), .s_stb_o  (s_stb_o),  .s_dat_i (s_dat_i),
      .s_ack_i  (s_ack_i), .s_err_i  (s_err_i),  .s_rty_i (s_rty_i),
      .grant_o  (grant_o), .timeout_o(timeout_o)
   );

   assign all_out = {m_dat_o, m_ack_o, m_err_o, m_rty_o, grant_o,
                     s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, timeout_o};

   // Reference map: first slave (lowest index) whose masked address equals its base.
   function automatic int model_decode(input logic [31:0] a);
      logic [31:0] base [NS];
      logic [31:0] mask [NS];
      base = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h2100_0000};
      mask = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFF00_0000};
      for (int i = 0; i < NS; i++)
         if ((a & mask[i]) == base[i]) return i;
      return -1;
   endfunction

   task automatic clear_inputs;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
      s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
   endtask

   // One transaction by master m, from an idle fabric, with a slave answering in cycle d.
   task automatic run_txn(input string tag, input int m, input logic [31:0] adr, input logic we,
                          input logic [31:0] wdat, input logic [3:0] sel, input int d,
                          input resp_e resp);
      int            tgt, last_stb, end_c;
      bit            tmo;
      resp_e         kind;
      logic [NS-1:0] e_stb;
      logic [NM-1:0] e_gnt, e_ack, e_err, e_rty;
      logic          e_tmo;
      logic [NM*32-1:0] e_mdat;
      logic [68:0]   e_bus;
      tgt  = model_decode(adr);
      tmo  = 1'b0;
      kind = (resp == R_BOTH) ? R_ERR : resp;
      if (tgt < 0) begin
         last_stb = 0; end_c = 1; kind = R_ERR;
      end else if (d <= TMO) begin
         last_stb = d; end_c = d;
      end else begin
         last_stb = TMO; end_c = TMO + 1; tmo = 1'b1; kind = R_ERR;
      end
      @(posedge clk); #1;
      m_adr_i[m*32 +: 32] = adr;
      m_dat_i[m*32 +: 32] = wdat;
      m_sel_i[m*4 +: 4]   = sel;
      m_we_i[m]  = we;
      m_cyc_i[m] = 1'b1;
      m_stb_i[m] = 1'b1;
      for (int k = 0; k <= end_c + 1; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
            if (k == end_c + 1) begin
               m_cyc_i[m] = 1'b0;
               m_stb_i[m] = 1'b0;
            end else if (k == d && tgt >= 0 && !tmo) begin
               if (resp == R_ACK || resp == R_BOTH) s_ack_i[tgt] = 1'b1;
               if (resp == R_ERR || resp == R_BOTH) s_err_i[tgt] = 1'b1;
               if (resp == R_RTY) s_rty_i[tgt] = 1'b1;
            end
         end
         @(negedge clk);
         e_stb = '0; e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0; e_mdat = '0; e_bus = '0;
         e_tmo = tmo && (k == end_c);
         if (k >= 1 && k <= last_stb) begin
            e_stb[tgt]          = 1'b1;
            e_mdat[m*32 +: 32]  = rdat[tgt];
            e_bus               = {adr, wdat, sel, we};
         end
         if (k >= 1 && k <= end_c) e_gnt[m] = 1'b1;
         if (k == end_c) begin
            case (kind)
               R_ACK:   e_ack[m] = 1'b1;
               R_RTY:   e_rty[m] = 1'b1;
               default: e_err[m] = 1'b1;
            endcase
         end
         total++;
         if ({s_cyc_o, s_stb_o, grant_o, m_ack_o, m_err_o, m_rty_o, timeout_o} !==
             {e_stb, e_stb, e_gnt, e_ack, e_err, e_rty, e_tmo}) begin
            bad++;
            $display("FAIL %s cyc%0d ctl got cyc=%b stb=%b gnt=%b ack=%b err=%b rty=%b to=%b want stb=%b gnt=%b ack=%b err=%b rty=%b to=%b",
                     tag, k, s_cyc_o, s_stb_o, grant_o, m_ack_o, m_err_o, m_rty_o, timeout_o,
                     e_stb, e_gnt, e_ack, e_err, e_rty, e_tmo);
         end
         total++;
         if (m_dat_o !== e_mdat) begin
            bad++;
            $display("FAIL %s cyc%0d m_dat_o got=%h want=%h", tag, k, m_dat_o, e_mdat);
         end
         total++;
         if ({s_adr_o, s_dat_o, s_sel_o, s_we_o} !== e_bus) begin
            bad++;
            $display("FAIL %s cyc%0d slave bus got=%h want=%h", tag, k,
                     {s_adr_o, s_dat_o, s_sel_o, s_we_o}, e_bus);
         end
      end
   endtask

   task automatic test_reset;
      @(posedge clk); #1;
      wb_rst_i = 1'b1;
      clear_inputs();
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (all_out !== '0) begin
         bad++;
         $display("FAIL reset outputs got=%h want=0", all_out);
      end
      @(posedge clk); #1;
      wb_rst_i = 1'b0;
   endtask

   task automatic test_single_write;
      run_txn("single_wr", 0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 1, R_ACK);
   endtask

   task automatic test_contention;
      logic [NM-1:0] want_gnt [7];
      logic [NM-1:0] want_ack [7];
      want_gnt = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
      want_ack = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
      test_reset();
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
         s_ack_i = '0;
         case (k)
            0: begin
               m_adr_i = {32'h0000_0080, 32'h0000_0040};
               m_cyc_i = 2'b11; m_stb_i = 2'b11;
            end
            1, 3, 5: s_ack_i[0] = 1'b1;
            2: begin m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0; end
            4: begin m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; end
            default: begin m_cyc_i = '0; m_stb_i = '0; end
         endcase
         @(negedge clk);
         total++;
         if ({grant_o, m_ack_o, m_err_o, m_rty_o} !== {want_gnt[k], want_ack[k], 4'b0000}) begin
            bad++;
            $display("FAIL contention cyc%0d gnt=%b ack=%b err=%b rty=%b want gnt=%b ack=%b",
                     k, grant_o, m_ack_o, m_err_o, m_rty_o, want_gnt[k], want_ack[k]);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [NS-1:0] want_stb [6];
      logic [NM-1:0] want_gnt [6];
      logic [NM-1:0] want_ack [6];
      want_stb = '{5'b00000, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00001};
      want_gnt = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
      want_ack = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         case (k)
            0: begin
               m_adr_i[0 +: 32] = 32'h2000_0004; m_sel_i[0 +: 4] = 4'hF;
               m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
            end
            2: wb_rst_i = 1'b1;
            4: begin
               wb_rst_i = 1'b0;
               m_adr_i[0 +: 32] = 32'h0000_0010;
               m_adr_i[32 +: 32] = 32'h0000_0020;
               m_cyc_i = 2'b11; m_stb_i = 2'b11;
            end
            5: s_ack_i[0] = 1'b1;
            default: ;
         endcase
         @(negedge clk);
         total++;
         if ({s_stb_o, grant_o, m_ack_o, m_err_o, m_rty_o, timeout_o} !==
             {want_stb[k], want_gnt[k], want_ack[k], 5'b00000}) begin
            bad++;
            $display("FAIL reset_mid cyc%0d stb=%b gnt=%b ack=%b err=%b rty=%b to=%b want stb=%b gnt=%b ack=%b",
                     k, s_stb_o, grant_o, m_ack_o, m_err_o, m_rty_o, timeout_o,
                     want_stb[k], want_gnt[k], want_ack[k]);
         end
         if (k == 3) begin
            total++;
            if (all_out !== '0) begin
               bad++;
               $display("FAIL reset_mid outputs got=%h want=0", all_out);
            end
         end
      end
      test_reset();
   endtask

   task automatic test_random(input int n);
      logic [31:0] adr;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 5))
            0:       adr = $urandom & 32'h0000_0FFF;
            1:       adr = 32'h1000_0000 | ($urandom & 32'h0000_00FF);
            2:       adr = 32'h2000_0000 | ($urandom & 32'h0000_00FF);
            3:       adr = 32'h2100_0000 | ($urandom & 32'h00FF_FFFF);
            4:       adr = 32'h3000_0000 | ($urandom & 32'h0FFF_FFFF);
            default: adr = 32'h2000_0100 | ($urandom & 32'h0000_00FF);
         endcase
         run_txn("random", int'($urandom_range(0, NM - 1)), adr, 1'($urandom), $urandom,
                 4'($urandom), int'($urandom_range(1, 6)), resp_e'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      wb_rst_i = 1'b1;
      clear_inputs();
      for (int i = 0; i < NS; i++) begin
         rdat[i] = $urandom;
         s_dat_i[i*32 +: 32] = rdat[i];
      end
      test_reset();
      test_single_write();
      run_txn("unmapped", 1, 32'h3000_0000, 1'b0, 32'h0, 4'hF, 1, R_ACK);
      run_txn("timeout",  0, 32'h2000_0004, 1'b0, 32'h0, 4'hF, 100, R_ACK);
      run_txn("overlap",  0, 32'h1000_0020, 1'b0, 32'h0, 4'hF, 1, R_ACK);
      run_txn("ack_err",  1, 32'h2100_0040, 1'b1, 32'h1234_5678, 4'h3, 2, R_BOTH);
      run_txn("retry",    1, 32'h2000_0010, 1'b0, 32'h0, 4'hF, 3, R_RTY);
      test_contention();
      test_reset_mid();
      test_random(40);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
